// File: rtl/pop_pkg.sv
// Shared definitions for the POP cycle monitor: FSM states, err bit indices
// and the default measurement counter width.
package pop_pkg;

  localparam int CNT_W_DEFAULT = 20;

  localparam int ERR_W       = 4;
  localparam int ERR_OVERLAP = 0;
  localparam int ERR_MWCNT   = 1;
  localparam int ERR_SAMPLE  = 2;
  localparam int ERR_SAT     = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUMP,
    ST_DARK1,
    ST_MW1,
    ST_FREE,
    ST_MW2,
    ST_DARK2,
    ST_PROBE,
    ST_TAIL
  } pop_state_e;

endpackage

// File: rtl/pop_edge_sync.sv
// Synchroniser for one asynchronous timing line plus registered level and
// rise/fall strobes, all three aligned to the same clk.
module pop_edge_sync #(
  parameter int SYNC_EN = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync_p1;

  generate
    if (SYNC_EN != 0) begin : g_two_flop
      logic meta_p0;
      logic meta_p1;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_p0 <= 1'b0;
          meta_p1 <= 1'b0;
        end else begin
          meta_p0 <= raw;
          meta_p1 <= meta_p0;
        end
      end
      assign sync_p1 = meta_p1;
    end else begin : g_one_flop
      logic meta_p0;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_p0 <= 1'b0;
        end else begin
          meta_p0 <= raw;
        end
      end
      assign sync_p1 = meta_p0;
    end
  endgenerate

  // Stage p2: lvl is the one-clk-delayed copy used for edge detection, and the
  // strobes are registered with it so level and edge describe the same clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      lvl  <= sync_p1;
      rise <= sync_p1 & ~lvl;
      fall <= ~sync_p1 & lvl;
    end
  end

endmodule

// File: rtl/pop_cycle_monitor.sv
// Measures pump/pi2/free/probe widths and pump period of each POP timing
// cycle, with overlap, MW-count, sample-window and saturation error flags.
module pop_cycle_monitor
  import pop_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pump,
  input  logic             probe,
  input  logic             MW,
  input  logic             sample,
  output logic [CNT_W-1:0] pump_width,
  output logic [CNT_W-1:0] pi2_width,
  output logic [CNT_W-1:0] free_width,
  output logic [CNT_W-1:0] probe_width,
  output logic [CNT_W-1:0] period,
  output logic             cycle_valid,
  output logic [ERR_W-1:0] err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic pump_l, pump_r, pump_f;
  logic probe_l, probe_r, probe_f;
  logic mw_l, mw_r, mw_f;
  logic smp_l, smp_r, smp_f;
  logic unused_smp_edges;

  pop_edge_sync #(.SYNC_EN(SYNC_EN)) u_sync_pump (
    .clk(clk), .reset(reset), .raw(pump),
    .lvl(pump_l), .rise(pump_r), .fall(pump_f)
  );
  pop_edge_sync #(.SYNC_EN(SYNC_EN)) u_sync_probe (
    .clk(clk), .reset(reset), .raw(probe),
    .lvl(probe_l), .rise(probe_r), .fall(probe_f)
  );
  pop_edge_sync #(.SYNC_EN(SYNC_EN)) u_sync_mw (
    .clk(clk), .reset(reset), .raw(MW),
    .lvl(mw_l), .rise(mw_r), .fall(mw_f)
  );
  pop_edge_sync #(.SYNC_EN(SYNC_EN)) u_sync_sample (
    .clk(clk), .reset(reset), .raw(sample),
    .lvl(smp_l), .rise(smp_r), .fall(smp_f)
  );

  // Only the sample level matters; its edges are not part of any measurement.
  assign unused_smp_edges = smp_r ^ smp_f;

  pop_state_e state, state_n;

  logic [CNT_W-1:0] pump_cnt, pi2_cnt, free_cnt, probe_cnt, period_cnt;
  logic [ERR_W-1:0] acc_err, cur_err, rep_err;
  logic cycle_end, truncated;
  logic pump_inc, pi2_ld, pi2_inc, free_ld, free_inc, probe_ld, probe_inc, per_inc;
  logic sat_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (pump_r) begin
      state_n = ST_PUMP;
    end else begin
      case (state)
        ST_PUMP:  if (pump_f)  state_n = ST_DARK1;
        ST_DARK1: if (mw_r)    state_n = ST_MW1;
        ST_MW1:   if (mw_f)    state_n = ST_FREE;
        ST_FREE:  if (mw_r)    state_n = ST_MW2;
        ST_MW2:   if (mw_f)    state_n = ST_DARK2;
        ST_DARK2: if (probe_r) state_n = ST_PROBE;
        ST_PROBE: if (probe_f) state_n = ST_TAIL;
        default:               state_n = state;
      endcase
    end
  end

  // Each counter loads 1 on the clk that opens its interval so that an
  // interval of N synchronised clks ends at exactly N.
  always_comb begin
    cycle_end = pump_r && (state != ST_IDLE);
    truncated = state inside {ST_PUMP, ST_DARK1, ST_MW1, ST_FREE, ST_MW2};
    pump_inc  = !pump_r && (state == ST_PUMP) && pump_l;
    pi2_ld    = !pump_r && (state == ST_DARK1) && mw_r;
    pi2_inc   = !pump_r && (state == ST_MW1) && mw_l;
    free_ld   = !pump_r && (state == ST_MW1) && mw_f;
    free_inc  = !pump_r && (state == ST_FREE) && !mw_l;
    probe_ld  = !pump_r && (state == ST_DARK2) && probe_r;
    probe_inc = !pump_r && (state == ST_PROBE) && probe_l;
    per_inc   = !pump_r && (state != ST_IDLE);
    sat_hit   = (pump_inc  && (&pump_cnt))  ||
                (pi2_inc   && (&pi2_cnt))   ||
                (free_inc  && (&free_cnt))  ||
                (probe_inc && (&probe_cnt)) ||
                (per_inc   && (&period_cnt));
  end

  always_comb begin
    cur_err              = '0;
    cur_err[ERR_OVERLAP] = (pump_l & probe_l) | (pump_l & mw_l) | (probe_l & mw_l);
    cur_err[ERR_MWCNT]   = !pump_r && mw_r && (state inside {ST_DARK2, ST_PROBE, ST_TAIL});
    cur_err[ERR_SAMPLE]  = smp_l & ~probe_l;
    cur_err[ERR_SAT]     = sat_hit;
    rep_err              = acc_err;
    rep_err[ERR_MWCNT]   = acc_err[ERR_MWCNT] | truncated;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pump_cnt   <= '0;
      pi2_cnt    <= '0;
      free_cnt   <= '0;
      probe_cnt  <= '0;
      period_cnt <= '0;
    end else if (pump_r) begin
      pump_cnt   <= CNT_ONE;
      pi2_cnt    <= '0;
      free_cnt   <= '0;
      probe_cnt  <= '0;
      period_cnt <= CNT_ONE;
    end else begin
      if (pump_inc) pump_cnt <= sat_inc(pump_cnt);
      if (pi2_ld) pi2_cnt <= CNT_ONE;
      else if (pi2_inc) pi2_cnt <= sat_inc(pi2_cnt);
      if (free_ld) free_cnt <= CNT_ONE;
      else if (free_inc) free_cnt <= sat_inc(free_cnt);
      if (probe_ld) probe_cnt <= CNT_ONE;
      else if (probe_inc) probe_cnt <= sat_inc(probe_cnt);
      if (per_inc) period_cnt <= sat_inc(period_cnt);
    end
  end

  // Conditions seen on the pump-rise clk already belong to the new cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_err <= '0;
    end else if (pump_r) begin
      acc_err <= cur_err;
    end else begin
      acc_err <= acc_err | cur_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pump_width  <= '0;
      pi2_width   <= '0;
      free_width  <= '0;
      probe_width <= '0;
      period      <= '0;
      err         <= '0;
      cycle_valid <= 1'b0;
    end else begin
      cycle_valid <= cycle_end;
      if (cycle_end) begin
        pump_width  <= pump_cnt;
        pi2_width   <= pi2_cnt;
        free_width  <= free_cnt;
        probe_width <= probe_cnt;
        period      <= period_cnt;
        err         <= rep_err;
      end
    end
  end

endmodule

// File: doc/pop_cycle_monitor.md
POP_CYCLE_MONITOR -- requirements
Module: pop_cycle_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 20, width of every measurement counter and output field (0.42 s at 2.5 MHz).
REQ-002 SHALL have parameter SYNC_EN, default 1; 1 = two-flop synchroniser on each of pump/probe/MW/sample, 0 = single register.
REQ-003 SHALL have port clk  input  1  2.5 MHz timing clock (CLKOP domain).
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports pump, probe, MW, sample  input  1 each  monitored POP timing lines, asynchronous to clk.
REQ-006 SHALL have port pump_width  output  CNT_W  clk cycles pump was high in the last completed cycle.
REQ-007 SHALL have port pi2_width  output  CNT_W  clk cycles first MW pulse was high.
REQ-008 SHALL have port free_width  output  CNT_W  clk cycles from first MW fall to second MW rise.
REQ-009 SHALL have port probe_width  output  CNT_W  clk cycles probe was high.
REQ-010 SHALL have port period  output  CNT_W  clk cycles between consecutive pump rises.
REQ-011 SHALL have port cycle_valid  output  1  one-clk strobe; all fields and err updated in the same clk.
REQ-012 SHALL have port err  output  4  [0] overlap, [1] MW pulse count != 2, [2] sample outside probe, [3] counter saturated.

Function
REQ-013 All measurement SHALL use the synchronised signals; edges are detected against a one-clk-delayed copy.
REQ-014 FSM states: IDLE, PUMP, DARK1, MW1, FREE, MW2, DARK2, PROBE, TAIL.
REQ-015 IDLE -> PUMP on pump rise; no output update on this first rise.
REQ-016 PUMP -> DARK1 on pump fall; DARK1 -> MW1 on MW rise; MW1 -> FREE on MW fall; FREE -> MW2 on MW rise; MW2 -> DARK2 on MW fall; DARK2 -> PROBE on probe rise; PROBE -> TAIL on probe fall.
REQ-017 A pump rise in any state other than IDLE SHALL end the cycle: latch fields, pulse cycle_valid, clear counters and err accumulator, go to PUMP.
REQ-018 A high pulse lasting N synchronised clks SHALL measure N; a gap lasting N clks SHALL measure N; period measures rise-to-rise distance.
REQ-019 Fields not reached in a truncated cycle SHALL be reported as 0 with err[1] set.
REQ-020 cycle_valid SHALL assert on the third rising clk after the first clk that samples raw pump high (SYNC_EN=1), second with SYNC_EN=0.
REQ-021 err[0] SHALL set if pump and probe, pump and MW, or probe and MW are high in the same clk.
REQ-022 err[1] SHALL set on a third MW rise in a cycle, or a cycle ending before MW2 completes.
REQ-023 err[2] SHALL set if sample is high in any clk where probe is low.
REQ-024 Counters SHALL saturate at 2^CNT_W-1, hold, and set err[3]; no wrap-around.
REQ-025 err bits SHALL accumulate over the cycle and be reported with that cycle's cycle_valid, not sticky across cycles.

Reset
REQ-026 On reset: FSM = IDLE, synchronisers and counters = 0, all width fields and period = 0, cycle_valid = 0, err = 0.
REQ-027 Reset asserted mid-cycle SHALL discard the partial cycle; first pump rise after release is treated as in IDLE.

Structure
REQ-028 Shared package pop_pkg SHALL hold the FSM state enumeration, err bit index constants and default CNT_W.
REQ-029 One sub-module pop_edge_sync (synchroniser + rise/fall detect, SYNC_EN parameter) SHALL be instantiated per input line.

Verification
REQ-030 Nominal: pump 100, gap 10, MW 5, free 40, MW 5, gap 10, probe 50 (sample = probe), period 500, two cycles -> second pump rise gives pump_width 100, pi2_width 5, free_width 40, probe_width 50, period 500, err 0.
REQ-031 Latency: pump rises at clk k, SYNC_EN=1 -> cycle_valid high only at clk k+3 for exactly one clk.
REQ-032 Three MW pulses in one cycle -> err = 4'b0010, other fields measured from first two pulses.
REQ-033 MW high during pump for 1 clk, sample high 1 clk before probe -> err = 4'b0101.
REQ-034 CNT_W=8, probe held 300 clks -> probe_width 255, err[3] = 1.
REQ-035 Reset pulsed during FREE, then nominal cycles -> no cycle_valid until second pump rise after release; values as REQ-030.
